// File: rtl/addsub_serial.sv
// addsub_serial: digit-serial signed add/sub, WIDTH+1-bit exact result.
// Define ADDSUB_SERIAL_SAT_EN to saturate m to the WIDTH-bit range on overflow.
module addsub_serial #(
  parameter int WIDTH = 4,
  parameter int DIGIT = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH:0]   m,
  output logic             ovf
);

  localparam int N  = WIDTH / DIGIT;
  localparam int CW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic             c_q, c_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic [WIDTH:0]   m_q, m_d;
  logic             ovf_q, ovf_d;
  logic             done_q, done_d;

  logic [DIGIT-1:0] a_dig;
  logic [DIGIT-1:0] b_dig;
  logic [DIGIT-1:0] s_dig;
  logic             c_out;
  logic [WIDTH-1:0] sum_w;
  logic [WIDTH:0]   m_ext;
  logic [WIDTH:0]   m_fin;
  logic             ovf_fin;
  logic             last;

  assign last = (cnt_q == CW'(N - 1));

  // Current digit sum, full sum with this digit merged in, final result.
  always_comb begin
    a_dig = a_q[int'(cnt_q) * DIGIT +: DIGIT];
    b_dig = b_q[int'(cnt_q) * DIGIT +: DIGIT];
    {c_out, s_dig} = {1'b0, a_dig}
                   + {1'b0, b_dig}
                   + {{DIGIT{1'b0}}, c_q};
    sum_w = res_q;
    sum_w[int'(cnt_q) * DIGIT +: DIGIT] = s_dig;
    // Sign of the widened sum: both sign-extended operands plus carry out.
    m_ext = {a_q[WIDTH-1] ^ b_q[WIDTH-1] ^ c_out, sum_w};
    ovf_fin = m_ext[WIDTH] ^ m_ext[WIDTH-1];
    m_fin = m_ext;
`ifdef ADDSUB_SERIAL_SAT_EN
    if (ovf_fin) begin
      m_fin = m_ext[WIDTH] ? {2'b11, {(WIDTH-1){1'b0}}}
                           : {2'b00, {(WIDTH-1){1'b1}}};
    end
`else
    m_fin = m_ext;
`endif
  end

  // Next-state and datapath update for the IDLE/RUN controller.
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    c_d     = c_q;
    cnt_d   = cnt_q;
    res_d   = res_q;
    m_d     = m_q;
    ovf_d   = ovf_q;
    done_d  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          a_d     = a;
          b_d     = sub ? ~b : b;
          c_d     = sub;
          cnt_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        res_d = sum_w;
        c_d   = c_out;
        cnt_d = cnt_q + 1'b1;
        if (last) begin
          state_d = IDLE;
          m_d     = m_fin;
          ovf_d   = ovf_fin;
          done_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      c_q     <= 1'b0;
      cnt_q   <= '0;
      res_q   <= '0;
      m_q     <= '0;
      ovf_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      c_q     <= c_d;
      cnt_q   <= cnt_d;
      res_q   <= res_d;
      m_q     <= m_d;
      ovf_q   <= ovf_d;
      done_q  <= done_d;
    end
  end

  assign busy = (state_q == RUN);
  assign done = done_q;
  assign m    = m_q;
  assign ovf  = ovf_q;

endmodule

// File: tb/tb_addsub_serial.sv
// tb_addsub_serial: WIDTH=4 at DIGIT 1/2/4 plus WIDTH=8 DIGIT=4,
// checked against an integer-arithmetic reference model.
module tb_addsub_serial;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n;
  logic [2:0] st;
  logic       sb;
  logic [3:0] a4, b4;
  logic [2:0] busy, done, ovf;
  logic [4:0] m [3];

  logic       st8, sb8;
  logic [7:0] a8, b8;
  logic       busy8, done8, ovf8;
  logic [8:0] m8;

  int nn [3] = '{4, 2, 1};
  int checks = 0;
  int errors = 0;

`ifdef ADDSUB_SERIAL_SAT_EN
  localparam logic [4:0] E1 = 5'b00111;
  localparam logic [4:0] E2 = 5'b11000;
  localparam logic [8:0] E8 = 9'h07F;
`else
  localparam logic [4:0] E1 = 5'b01111;
  localparam logic [4:0] E2 = 5'b10001;
  localparam logic [8:0] E8 = 9'h080;
`endif

  addsub_serial #(.WIDTH(4), .DIGIT(1)) u_d1 (
    .clk(clk), .rst_n(rst_n), .start(st[0]), .sub(sb),
    .a(a4), .b(b4), .busy(busy[0]), .done(done[0]),
    .m(m[0]), .ovf(ovf[0])
  );

  addsub_serial #(.WIDTH(4), .DIGIT(2)) u_d2 (
    .clk(clk), .rst_n(rst_n), .start(st[1]), .sub(sb),
    .a(a4), .b(b4), .busy(busy[1]), .done(done[1]),
    .m(m[1]), .ovf(ovf[1])
  );

  addsub_serial #(.WIDTH(4), .DIGIT(4)) u_d4 (
    .clk(clk), .rst_n(rst_n), .start(st[2]), .sub(sb),
    .a(a4), .b(b4), .busy(busy[2]), .done(done[2]),
    .m(m[2]), .ovf(ovf[2])
  );

  addsub_serial #(.WIDTH(8), .DIGIT(4)) u_w8 (
    .clk(clk), .rst_n(rst_n), .start(st8), .sub(sb8),
    .a(a8), .b(b8), .busy(busy8), .done(done8),
    .m(m8), .ovf(ovf8)
  );

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [5:0] model(input logic [3:0] x,
                                       input logic [3:0] y,
                                       input logic s);
    int r;
    logic o;
    logic [4:0] mm;
    r  = s ? int'($signed(x)) - int'($signed(y))
           : int'($signed(x)) + int'($signed(y));
    o  = (r > 7) || (r < -8);
    mm = r[4:0];
`ifdef ADDSUB_SERIAL_SAT_EN
    if (o) mm = (r > 0) ? 5'b00111 : 5'b11000;
`endif
    return {o, mm};
  endfunction

  task automatic run_op(input logic [3:0] x, input logic [3:0] y,
                        input logic s, input logic [4:0] em,
                        input logic eo, input bit spur);
    int first [3];
    int cnt [3];
    logic [4:0] mc [3];
    logic oc [3];
    @(negedge clk);
    a4 = x; b4 = y; sb = s; st = 3'b111;
    @(negedge clk);
    st = 3'b000;
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("busy%0d", i), busy[i], 1);
      first[i] = -1;
      cnt[i] = 0;
      mc[i] = '0;
      oc[i] = 1'b0;
    end
    a4 = 4'($urandom); b4 = 4'($urandom); sb = 1'($urandom);
    for (int k = 1; k <= 9; k++) begin
      @(negedge clk);
      for (int i = 0; i < 3; i++) begin
        if (done[i]) begin
          cnt[i]++;
          if (first[i] < 0) begin
            first[i] = k;
            mc[i] = m[i];
            oc[i] = ovf[i];
          end
        end
      end
      if (spur) st[0] = (k == 2);
    end
    st = 3'b000;
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("lat%0d", i), first[i], nn[i]);
      chk($sformatf("ndone%0d", i), cnt[i], 1);
      chk($sformatf("m%0d_%h%h%b", i, x, y, s), mc[i], em);
      chk($sformatf("ovf%0d_%h%h%b", i, x, y, s), oc[i], eo);
      chk($sformatf("mhold%0d", i), m[i], em);
    end
  endtask

  task automatic back_to_back();
    @(negedge clk);
    a4 = 4'd3; b4 = 4'hE; sb = 1'b0; st[0] = 1'b1;
    @(negedge clk);
    st[0] = 1'b0;
    repeat (3) @(negedge clk);
    a4 = 4'd5; b4 = 4'd6; sb = 1'b1; st[0] = 1'b1;
    @(negedge clk);
    chk("b2b_done1", done[0], 1);
    chk("b2b_m1", m[0], 5'b00001);
    chk("b2b_ovf1", ovf[0], 0);
    @(negedge clk);
    st[0] = 1'b0;
    for (int k = 0; k < 4; k++) begin
      chk("b2b_gap", done[0], 0);
      chk("b2b_hold", m[0], 5'b00001);
      @(negedge clk);
    end
    chk("b2b_done2", done[0], 1);
    chk("b2b_m2", m[0], 5'b11111);
    chk("b2b_ovf2", ovf[0], 0);
  endtask

  task automatic reset_mid_run();
    int cnt;
    @(negedge clk);
    a4 = 4'd7; b4 = 4'h8; sb = 1'b1; st[0] = 1'b1;
    @(negedge clk);
    st[0] = 1'b0;
    @(negedge clk);
    chk("rst_pre_busy", busy[0], 1);
    rst_n = 1'b0;
    #1;
    chk("rst_busy", busy[0], 0);
    chk("rst_done", done[0], 0);
    chk("rst_m", m[0], 0);
    chk("rst_ovf", ovf[0], 0);
    @(negedge clk);
    rst_n = 1'b1;
    cnt = 0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      if (done[0]) cnt++;
    end
    chk("rst_nodone", cnt, 0);
    chk("rst_idle", busy[0], 0);
  endtask

  task automatic wide_case();
    int first;
    @(negedge clk);
    a8 = 8'h7F; b8 = 8'h01; sb8 = 1'b0; st8 = 1'b1;
    @(negedge clk);
    st8 = 1'b0;
    chk("w8_busy", busy8, 1);
    first = -1;
    for (int k = 1; k <= 5; k++) begin
      @(negedge clk);
      if (done8 && first < 0) first = k;
    end
    chk("w8_lat", first, 2);
    chk("w8_m", m8, E8);
    chk("w8_ovf", ovf8, 1);
  endtask

  initial begin
    int off;
    logic [8:0] idx;
    logic [5:0] e;
    rst_n = 1'b0;
    st = 3'b000; sb = 1'b0; a4 = '0; b4 = '0;
    st8 = 1'b0; sb8 = 1'b0; a8 = '0; b8 = '0;
    repeat (2) @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("r_busy%0d", i), busy[i], 0);
      chk($sformatf("r_done%0d", i), done[i], 0);
      chk($sformatf("r_m%0d", i), m[i], 0);
      chk($sformatf("r_ovf%0d", i), ovf[i], 0);
    end
    chk("r_m8", m8, 0);
    rst_n = 1'b1;

    run_op(4'b0111, 4'b1000, 1'b1, E1, 1'b1, 1'b0);
    run_op(4'b1000, 4'b0111, 1'b1, E2, 1'b1, 1'b0);
    run_op(4'b0011, 4'b1110, 1'b0, 5'b00001, 1'b0, 1'b1);
    wide_case();
    back_to_back();
    reset_mid_run();

    off = int'($urandom);
    for (int i = 0; i < 512; i++) begin
      idx = 9'((i * 157 + off) & 511);
      e = model(idx[3:0], idx[7:4], idx[8]);
      run_op(idx[3:0], idx[7:4], idx[8], e[4:0], e[5], 1'b0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
